// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Purpose  : Instruction queue between fetch and decode. Buffers up to DEPTH
//            {pc, pc4, inst} entries in FIFO order behind a valid/ready
//            handshake on each side. A synchronous flush (branch/jump
//            redirect) drops every buffered entry so wrong-path instructions
//            never reach decode.
// Ports    : clk        - clock, all state updates on the rising edge
//            rst        - asynchronous, active-low reset
//            flush      - discard all entries at the next edge
//            in_valid   - fetch presents an entry
//            in_ready   - queue accepts an entry this cycle
//            in_pc      - PC of the fetched instruction
//            in_pc4     - PC+4 of the fetched instruction
//            in_inst    - fetched instruction word
//            out_valid  - head entry is valid
//            out_ready  - decode consumes the head entry this cycle
//            out_pc     - head PC (0 when out_valid=0)
//            out_pc4    - head PC+4 (0 when out_valid=0)
//            out_inst   - head instruction (NOP when out_valid=0)
//            count      - current occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter int unsigned     DEPTH = 4,
    parameter int unsigned     XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_pc4,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_pc4,
    output logic [XLEN-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    // Index width; pointers carry one extra wrap bit above it.
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] c_ptr_one = (AW + 1)'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [XLEN-1:0]  r_pc_mem   [DEPTH];
    logic [XLEN-1:0]  r_pc4_mem  [DEPTH];
    logic [XLEN-1:0]  r_inst_mem [DEPTH];

    // ------------------------------------------------------------------------
    // Status and handshakes
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Equal pointers mean empty; same slot with opposite wrap bits means full.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                     (r_wptr[AW] != r_rptr[AW]);

    // Ready depends only on stored state, flush and reset: a pop in the same
    // cycle never opens a slot for a push while full.
    assign in_ready  = !w_full && !flush && rst;
    // Flush hides the head in the redirect cycle so decode cannot consume a
    // wrong-path instruction.
    assign out_valid = !w_empty && !flush && rst;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Occupancy is the modular pointer distance, so it moves by +1/-1 on a
    // lone push/pop and holds when both happen together.
    assign count = r_wptr - r_rptr;

    // ------------------------------------------------------------------------
    // Head read-out, forced to a harmless NOP bubble when nothing is valid
    // ------------------------------------------------------------------------
    always_comb begin
        out_pc   = '0;
        out_pc4  = '0;
        out_inst = NOP;
        if (out_valid) begin
            out_pc   = r_pc_mem[r_rptr[AW-1:0]];
            out_pc4  = r_pc4_mem[r_rptr[AW-1:0]];
            out_inst = r_inst_mem[r_rptr[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------------
    // Pointers: flush returns both to zero; otherwise advance on handshakes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage: cleared on reset only; flush leaves stale contents behind since
    // the pointers alone decide what is visible.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pc_mem[i]   <= '0;
                r_pc4_mem[i]  <= '0;
                r_inst_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_mem[r_wptr[AW-1:0]]   <= in_pc;
            r_pc4_mem[r_wptr[AW-1:0]]  <= in_pc4;
            r_inst_mem[r_wptr[AW-1:0]] <= in_inst;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_queue
// Purpose  : Self-checking bench for if_id_queue. The driver records every
//            entry it expects the queue to accept in a scoreboard queue; a
//            monitor on the falling edge compares the DUT's presented head,
//            handshakes and occupancy with that bounded-FIFO reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam int          DEPTH = 4;
    localparam int          XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_pc4;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;
    logic [2:0]  count;

    if_id_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .NOP   (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_pc4    (in_pc4),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .out_inst  (out_inst),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: entries the reference FIFO holds, oldest first.
    entry_t sb[$];
    logic   push_now;
    int     n_checks;
    int     n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: outputs are sampled mid-cycle, after this cycle's inputs are
    // set. The just-issued push is not yet in the DUT, so it is subtracted
    // from the reference occupancy.
    // ------------------------------------------------------------------------
    int     mon_occ;
    logic   mon_ir;
    logic   mon_ov;
    entry_t mon_head;

    always @(negedge clk) begin
        mon_occ = sb.size() - (push_now ? 1 : 0);
        mon_ir  = rst && !flush && (mon_occ < DEPTH);
        mon_ov  = rst && !flush && (mon_occ > 0);
        chk("count",     64'(count),     64'(mon_occ));
        chk("in_ready",  64'(in_ready),  64'(mon_ir));
        chk("out_valid", 64'(out_valid), 64'(mon_ov));
        if (mon_ov) begin
            mon_head = sb[0];
            chk("out_pc",   64'(out_pc),   64'(mon_head.pc));
            chk("out_pc4",  64'(out_pc4),  64'(mon_head.pc4));
            chk("out_inst", 64'(out_inst), 64'(mon_head.inst));
            if (out_ready) begin
                void'(sb.pop_front());
            end
        end else begin
            chk("idle_pc",   64'(out_pc),   64'd0);
            chk("idle_pc4",  64'(out_pc4),  64'd0);
            chk("idle_inst", 64'(out_inst), 64'(NOP));
        end
        if (rst && flush) begin
            sb.delete();
        end
    end

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    task automatic cycle(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        entry_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_pc4    = pc + 32'd4;
        in_inst   = $urandom;
        out_ready = ordy;
        flush     = fl;
        if (rst && v && !fl && (sb.size() < DEPTH)) begin
            e.pc     = in_pc;
            e.pc4    = in_pc4;
            e.inst   = in_inst;
            sb.push_back(e);
            push_now = 1'b1;
        end else begin
            push_now = 1'b0;
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, $urandom, ordy, 1'b0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        push_now  = 1'b0;
    endtask

    // Drop reset between edges and look at the outputs before any edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        push_now  = 1'b0;
        sb.delete();
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready",  64'(in_ready),  64'd0);
        chk("arst_count",     64'(count),     64'd0);
        chk("arst_out_inst",  64'(out_inst),  64'(NOP));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        push_now  = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_pc4    = '0;
        in_inst   = '0;
        rst       = 1'b1;
        #2;
        rst       = 1'b0;

        // Reset state held for a couple of cycles, then fill to full.
        idle(1'b0);
        idle(1'b1);
        release_rst();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 1'b0, 1'b0);
        cycle(1'b1, 32'h10, 1'b0, 1'b0);                 // refused: full

        // Drain in order, then empty.
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Streaming across the pointer wrap.
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
        idle(1'b1);

        // Full with a simultaneous pop: pop taken, push refused.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        cycle(1'b1, 32'h3F0, 1'b1, 1'b0);
        idle(1'b0);                                      // count 3, ready again

        // Flush at count 3 with both handshakes requested.
        cycle(1'b1, 32'h400, 1'b1, 1'b1);
        idle(1'b1);
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset at count 2.
        cycle(1'b1, 32'h500, 1'b0, 1'b0);
        cycle(1'b1, 32'h504, 1'b0, 1'b0);
        async_reset();
        idle(1'b1);
        release_rst();
        idle(1'b1);
        idle(1'b1);
        cycle(1'b1, 32'h600, 1'b1, 1'b0);
        idle(1'b1);

        // Random traffic with occasional redirects.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60,
                  $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 4);
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and decode. It accepts one fetched instruction per cycle, together with its PC and PC+4, over a valid/ready handshake. It buffers up to DEPTH entries in FIFO order and presents the oldest entry to decode over a second valid/ready handshake. A synchronous flush, driven by branch/jump redirect, discards every buffered entry so that wrong-path instructions never reach decode.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 32, width of the PC and instruction fields
- NOP, 32'h0000_0013, value driven on out_inst whenever out_valid=0
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; one clock, reset asynchronous and active-low (rst=0 resets)
- flush  in  1  discard all entries (redirect from execute)
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  queue can accept an entry this cycle
- in_pc  in  XLEN  PC of the fetched instruction
- in_pc4  in  XLEN  PC+4 of the fetched instruction
- in_inst  in  XLEN  fetched instruction word
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode consumes the head entry this cycle
- out_pc  out  XLEN  head PC
- out_pc4  out  XLEN  head PC+4
- out_inst  out  XLEN  head instruction, or NOP when invalid
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage is a circular array of {pc, pc4, inst}.
- Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty when the pointers are equal
  - full when the low bits are equal and the MSBs differ
- push = in_valid & in_ready; the entry is written at wptr and wptr increments (mod 2·DEPTH).
- pop = out_valid & out_ready; rptr increments.
- in_ready = !full & !flush & rst. No bypass when full: a pop in the same cycle does not open a slot until the next cycle.
- out_valid = !empty & !flush.
- out_pc, out_pc4 and out_inst read the entry at rptr combinationally. When out_valid=0, out_pc=0, out_pc4=0 and out_inst=NOP.
- count = wptr − rptr (modular). It updates by +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
- Flush: at the next edge wptr=rptr=0 and count=0. Any push or pop in the flush cycle is suppressed (in_ready and out_valid are already 0). Array contents are not cleared.
- Reset (rst=0, asynchronous):
  - pointers=0, count=0, array=0
  - while asserted: in_ready=0, out_valid=0, out_inst=NOP
  - the first push is accepted on the first edge after rst rises.
- Reset asserted mid-operation drops all entries immediately, with no partial pointer update.
- in_* content is ignored when in_valid=0, and out_ready is ignored when out_valid=0.

## Timing
- Latency: an entry pushed at edge N appears on out_* with out_valid=1 after edge N, i.e. in cycle N+1. There is no same-cycle pass-through from an empty queue.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- Full: in_ready falls in the cycle after the DEPTH-th push. It rises in the cycle after the first pop.
- Empty: out_valid falls in the cycle after the last pop unless a push occurred in the same cycle.
- Wrap-around: the pointer low bits roll from DEPTH−1 to 0 and the MSB toggles. FIFO order is preserved across the wrap.
- Flush with rst high takes effect on that edge. In the following cycle: count=0, out_valid=0, in_ready=1.
- Every output is a function of registered state plus flush/rst only. There is no combinational path from in_valid to out_* or from out_ready to in_ready.

## Test plan
- Reset then fill: hold out_ready=0 and push PCs 0x00, 0x04, 0x08, 0x0C (DEPTH=4). Required:
  - count goes 1, 2, 3, 4
  - in_ready=0 after the 4th push
  - out_pc=0x00 and out_inst equals the first word
- Drain and order: from full, set out_ready=1 and in_valid=0. Required: out_pc reads 0x00, 0x04, 0x08, 0x0C on successive cycles, then out_valid=0, out_inst=0x00000013 and count=0.
- Streaming and wrap: push and pop every cycle for 10 entries, PCs 0x100 upward. Required:
  - out_pc sequence 0x100, 0x104, … with a one-cycle lag
  - count holds 1
  - no entry lost across the pointer wrap
- Full with simultaneous pop: at count=4 assert in_valid=1 and out_ready=1. Required: the pop happens and the push is refused (in_ready=0). The next cycle shows count=3 and in_ready=1.
- Flush mid-stream: at count=3 assert flush with in_valid=1 and out_ready=1. Required:
  - in that cycle in_ready=0 and out_valid=0
  - next cycle count=0 and out_valid=0
  - the next pushed PC 0x200 is the first one output
- Async reset mid-operation: drop rst between edges at count=2. Required: out_valid=0, in_ready=0 and count=0 immediately, without waiting for a clock edge. After rst returns high the queue stays empty until a new push.
